in_tap_delay_line: RTL

//  Parametrised input tap delay line for the SC FIR datapath; one instance replaces the fixed stride-1/2/4 variants.

---
 rtl/in_tap_delay_line_if.sv | 30 +++
 rtl/in_tap_delay_line.sv | 102 ++++++++++
 2 files changed

// File: rtl/in_tap_delay_line_if.sv
// Bus bundle for the SC FIR input tap delay line: sample/control inputs and tap outputs.
interface in_tap_delay_line_if #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned TAPS       = 39,
  parameter int unsigned MAX_STRIDE = 4,
  parameter int unsigned SEL_W      = 2
);
  localparam int unsigned DEPTH = MAX_STRIDE * TAPS;
  localparam int unsigned FC_W  = $clog2(DEPTH + 1);

  logic                        in_valid;
  logic [WIDTH-1:0]            in;
  logic [SEL_W-1:0]            stride_sel;
  logic                        flush;
  logic [TAPS-1:0][WIDTH-1:0]  out;
  logic [SEL_W-1:0]            stride_q;
  logic [FC_W-1:0]             fill_count;
  logic                        taps_full;
  logic                        out_strobe;

  modport master (
    output in_valid, in, stride_sel, flush,
    input  out, stride_q, fill_count, taps_full, out_strobe
  );

  modport slave (
    input  in_valid, in, stride_sel, flush,
    output out, stride_q, fill_count, taps_full, out_strobe
  );
endinterface

// File: rtl/in_tap_delay_line.sv
// Input tap delay line with runtime stride, input stall, flush and fill tracking.
module in_tap_delay_line #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned TAPS       = 39,
  parameter int unsigned MAX_STRIDE = 4,
  parameter int unsigned SEL_W      = 2
) (
  input logic              clock,
  input logic              reset,
  in_tap_delay_line_if.slave bus
);
  localparam int unsigned DEPTH    = MAX_STRIDE * TAPS;
  localparam int unsigned FC_W     = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LOG2_MAX = $clog2(MAX_STRIDE);

  logic [WIDTH-1:0]           chain [DEPTH];
  logic [SEL_W-1:0]           stride_q;
  logic [FC_W-1:0]            fill_count;
  logic                       taps_full;
  logic                       out_strobe;

  logic [SEL_W-1:0]           sel_clamped_c;
  logic [FC_W-1:0]            target_c;
  logic [FC_W-1:0]            fill_d;
  logic                       taps_full_d;
  logic                       out_strobe_d;
  logic                       shift_c;
  logic [TAPS-1:0][WIDTH-1:0] out_c;

  // Clamp the requested stride code to the deepest supported spacing.
  always_comb begin
    sel_clamped_c = bus.stride_sel;
    if (bus.stride_sel > SEL_W'(LOG2_MAX)) begin
      sel_clamped_c = SEL_W'(LOG2_MAX);
    end
    target_c = FC_W'(TAPS << sel_clamped_c);
  end

  // Next fill/flag state: flush beats stride change, which beats a plain shift.
  always_comb begin
    shift_c      = 1'b0;
    fill_d       = fill_count;
    taps_full_d  = taps_full;
    out_strobe_d = 1'b0;
    if (bus.flush) begin
      fill_d      = '0;
      taps_full_d = 1'b0;
    end else if (sel_clamped_c != stride_q) begin
      shift_c     = bus.in_valid;
      fill_d      = bus.in_valid ? FC_W'(1) : '0;
      taps_full_d = 1'b0;
    end else if (bus.in_valid) begin
      shift_c      = 1'b1;
      fill_d       = (fill_count >= target_c) ? target_c : fill_count + FC_W'(1);
      taps_full_d  = (fill_d == target_c);
      out_strobe_d = (fill_d == target_c);
    end
  end

  // Control registers; stride code always tracks the clamped request.
  always_ff @(posedge clock) begin
    if (reset) begin
      stride_q   <= sel_clamped_c;
      fill_count <= '0;
      taps_full  <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      stride_q   <= sel_clamped_c;
      fill_count <= fill_d;
      taps_full  <= taps_full_d;
      out_strobe <= out_strobe_d;
    end
  end

  // Sample chain: cleared by reset/flush, shifts only on accepted samples.
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        chain[i] <= '0;
      end
    end else if (shift_c) begin
      chain[0] <= bus.in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  // Tap k picks chain[(k+1)*stride-1] straight from the registered chain.
  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      out_c[k] = chain[IDX_W'(((k + 1) << stride_q) - 1)];
    end
  end

  assign bus.out        = out_c;
  assign bus.stride_q   = stride_q;
  assign bus.fill_count = fill_count;
  assign bus.taps_full  = taps_full;
  assign bus.out_strobe = out_strobe;
endmodule
